debounce_bank: RTL

Parametrised multi-channel push-button debouncer, the successor to the single-input three-sample debouncer. It sits between raw board pins (push buttons, switches) and the control logic, such as the lock state machine. Each channel is synchronised, then filtered with a per-channel stability counter clocked by one shared tick prescaler. It produces a debounced level plus single-cycle rise and fall pulses per channel, with optional long-press detection.

---
 rtl/debounce_pkg.sv | 33 +++
 rtl/debounce_chan.sv | 141 ++++++++++++++
 rtl/debounce_bank.sv | 86 ++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : debounce_pkg                                               |
// | Description : Shared constants, the per-channel output record and a      |
// |               counter-width helper for the debounce_bank family.         |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package debounce_pkg;

   // Default configuration: a 250000-cycle tick at 50 MHz is a 5 ms sample.
   localparam int DB_TICK_DIV_DEF     = 250000;
   localparam int DB_STABLE_TICKS_DEF = 4;
   localparam int DB_LONG_TICKS_DEF   = 200;

   // Everything one channel reports to the bank.
   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
      logic long_press;
   } db_chan_out_t;

   // Bits needed to hold values 0..max_val. Never returns less than 1, so a
   // counter whose only legal value is 0 still gets a real (1-bit) register.
   function automatic int db_cnt_width(input int max_val);
      int w;
      w = (max_val < 1) ? 1 : $clog2(max_val + 1);
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : debounce_chan                                              |
// | Description : One debounce channel: two-flop synchroniser, tick-sampled  |
// |               stability filter, registered rise/fall pulses and an       |
// |               optional long-press pulse.                                 |
// | Ports       : clk     - system clock                                     |
// |               rst_n   - synchronous active-low reset                     |
// |               tick    - one-cycle sample strobe from the shared prescaler|
// |               pb      - raw asynchronous button input                    |
// |               o_level - debounced level                                  |
// |               o_rise  - one-cycle pulse on debounced 0->1                |
// |               o_fall  - one-cycle pulse on debounced 1->0                |
// |               o_long  - one-cycle long-press pulse (0 when disabled)     |
// | Config      : define DEBOUNCE_LONG_PRESS_EN to build long-press logic    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DB_STABLE_TICKS_DEF,
   parameter int LONG_TICKS   = DB_LONG_TICKS_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic pb,
   output logic o_level,
   output logic o_rise,
   output logic o_fall,
   output logic o_long
);

   localparam int                 c_CNT_W    = db_cnt_width(STABLE_TICKS);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_TICKS - 1);

   logic               r_s1;
   logic               r_s2;
   logic               r_db;
   logic               r_rise;
   logic               r_fall;
   logic [c_CNT_W-1:0] r_cnt;

   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic               w_db_nxt;
   logic               w_rise_nxt;
   logic               w_fall_nxt;

   // ---------------------------------------------------------------------
   // Synchroniser: pb is asynchronous to clk, so only r_s2 is trusted.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= pb;
         r_s2 <= r_s1;
      end
   end

   // ---------------------------------------------------------------------
   // Stability filter. The counter tracks how many consecutive ticks have
   // disagreed with the accepted level; any agreeing tick restarts it, and
   // the STABLE_TICKS-th disagreeing tick flips the level. Edge pulses are
   // computed here so they land on the same edge as the level change.
   // ---------------------------------------------------------------------
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_db_nxt   = r_db;
      w_rise_nxt = 1'b0;
      w_fall_nxt = 1'b0;
      if (tick) begin
         if (r_s2 == r_db) begin
            w_cnt_nxt = '0;
         end else if (r_cnt == c_CNT_LAST) begin
            w_db_nxt   = r_s2;
            w_cnt_nxt  = '0;
            w_rise_nxt = r_s2;
            w_fall_nxt = ~r_s2;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_db   <= 1'b0;
         r_cnt  <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_db   <= w_db_nxt;
         r_cnt  <= w_cnt_nxt;
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
      end
   end

   assign o_level = r_db;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

`ifdef DEBOUNCE_LONG_PRESS_EN
   // ---------------------------------------------------------------------
   // Long press: count ticks spent debounced-high, saturating at
   // LONG_TICKS. The pulse fires only on the increment that reaches the
   // limit, so a held button produces it exactly once per press.
   // ---------------------------------------------------------------------
   localparam int                  c_HOLD_W   = db_cnt_width(LONG_TICKS);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_TICKS);

   logic [c_HOLD_W-1:0] r_hold;
   logic                r_long;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hold <= '0;
         r_long <= 1'b0;
      end else begin
         r_long <= 1'b0;
         if (!r_db) begin
            r_hold <= '0;
         end else if (tick && (r_hold != c_HOLD_MAX)) begin
            r_hold <= r_hold + 1'b1;
            r_long <= (r_hold == (c_HOLD_MAX - 1'b1));
         end
      end
   end

   assign o_long = r_long;
`else
   // Long-press logic not built; LONG_TICKS has no effect.
   logic w_unused_long_cfg;
   assign w_unused_long_cfg = (LONG_TICKS != 0);
   assign o_long            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : debounce_bank                                              |
// | Description : Multi-channel push-button debouncer. One free-running      |
// |               prescaler produces the sample tick shared by CHANNELS      |
// |               independent debounce_chan instances.                       |
// | Ports       : clk     - system clock, single domain                      |
// |               rst_n   - synchronous active-low reset                     |
// |               pb_in   - raw asynchronous button inputs [CHANNELS]        |
// |               db_o    - debounced levels [CHANNELS]                      |
// |               rise_o  - one-cycle debounced 0->1 pulses [CHANNELS]       |
// |               fall_o  - one-cycle debounced 1->0 pulses [CHANNELS]       |
// |               long_o  - one-cycle long-press pulses [CHANNELS]           |
// | Config      : define DEBOUNCE_LONG_PRESS_EN to enable long_o; otherwise  |
// |               long_o is tied to 0                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int TICK_DIV     = DB_TICK_DIV_DEF,
   parameter int STABLE_TICKS = DB_STABLE_TICKS_DEF,
   parameter int LONG_TICKS   = DB_LONG_TICKS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] pb_in,
   output logic [CHANNELS-1:0] db_o,
   output logic [CHANNELS-1:0] rise_o,
   output logic [CHANNELS-1:0] fall_o,
   output logic [CHANNELS-1:0] long_o
);

   // With TICK_DIV == 1 the counter has a single legal value (0), so the
   // tick compare is always true and a tick fires every cycle.
   localparam int                  c_TICK_W    = db_cnt_width(TICK_DIV - 1);
   localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

   logic [c_TICK_W-1:0] r_tick_cnt;
   logic                w_tick;

   // ---------------------------------------------------------------------
   // Shared prescaler. Free-running from reset; its phase is deliberately
   // not aligned to input activity.
   // ---------------------------------------------------------------------
   assign w_tick = (r_tick_cnt == c_TICK_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Channel array
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      db_chan_out_t w_out;

      debounce_chan #(
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .tick    (w_tick),
         .pb      (pb_in[gi]),
         .o_level (w_out.level),
         .o_rise  (w_out.rise),
         .o_fall  (w_out.fall),
         .o_long  (w_out.long_press)
      );

      assign db_o[gi]   = w_out.level;
      assign rise_o[gi] = w_out.rise;
      assign fall_o[gi] = w_out.fall;
      assign long_o[gi] = w_out.long_press;
   end

endmodule
`default_nettype wire
